// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the management-SoC to user-area Wishbone bridge.
// Contents:
//   state_e      - bridge FSM states (idle, downstream access, upstream response)
//   ERR_DATA_DEF - default read data returned for unmapped or timed-out reads
//   TMO_W        - width of the per-access timeout counter
//   idx_width()  - bits needed to index N targets (never less than 1)
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned TMO_W        = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational region decoder for the user-area window.
// The window starts at BASE_ADDR and holds N_SLV contiguous regions of 2**SLV_AW bytes.
// Ports:
//   i_adr  in  AW      upstream byte address
//   o_hit  out 1       address falls inside the window
//   o_idx  out IW      target index (valid only when o_hit)
//   o_off  out SLV_AW  byte offset inside the selected region
module wb_addr_decoder
  import wb_bridge_pkg::*;
#(
  parameter int unsigned   N_SLV     = 4,
  parameter int unsigned   AW        = 32,
  parameter int unsigned   SLV_AW    = 20,
  parameter int unsigned   IW        = 2,
  parameter logic [AW-1:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic [AW-1:0]     i_adr,
  output logic              o_hit,
  output logic [IW-1:0]     o_idx,
  output logic [SLV_AW-1:0] o_off
);

  // One extra bit so a window that runs past the top of the address space does not wrap
  // around and alias low addresses.
  localparam logic [AW:0] SlvSize = (AW+1)'(1) << SLV_AW;
  localparam logic [AW:0] Span    = SlvSize * (AW+1)'(N_SLV);
  localparam logic [AW:0] BaseExt = {1'b0, BASE_ADDR};
  localparam logic [AW:0] EndExt  = BaseExt + Span;

  logic [AW:0]          w_adr_ext;
  logic [SLV_AW+IW-1:0] w_rel;

  assign w_adr_ext = {1'b0, i_adr};
  // Only the offset and index bits of the relative address matter once hit is known.
  assign w_rel     = (SLV_AW+IW)'(w_adr_ext - BaseExt);

  assign o_hit = (w_adr_ext >= BaseExt) && (w_adr_ext < EndExt);
  assign o_idx = w_rel[SLV_AW +: IW];
  assign o_off = w_rel[SLV_AW-1:0];

endmodule

// File: rtl/wb_mprj_bridge.sv
// Wishbone-classic bridge from the management-SoC slave port to N_SLV user-area targets.
// One transfer at a time: decode, forward to one target, register the response, and
// answer unmapped or hung (timed-out) accesses with ERR_DATA plus an error pulse/count.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i upstream request
//   wbs_ack_o, wbs_dat_o         upstream response (registered, ack is a 1-cycle pulse)
//   m_cyc_o, m_stb_o             per-target cycle/strobe (one-hot or zero)
//   m_we/sel/adr/dat_o           shared downstream request fields
//   m_ack_i, m_dat_i             per-target ack and read data (target k at [k*DW +: DW])
//   err_irq_o, err_count_o       error pulse and saturating error count
module wb_mprj_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned   N_SLV     = 4,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned   SLV_AW    = 20,
  parameter int unsigned   TIMEOUT   = 255,
  parameter logic [DW-1:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DW/8-1:0]     wbs_sel_i,
  input  logic [AW-1:0]       wbs_adr_i,
  input  logic [DW-1:0]       wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]    m_cyc_o,
  output logic [N_SLV-1:0]    m_stb_o,
  output logic                m_we_o,
  output logic [DW/8-1:0]     m_sel_o,
  output logic [SLV_AW-1:0]   m_adr_o,
  output logic [DW-1:0]       m_dat_o,
  input  logic [N_SLV-1:0]    m_ack_i,
  input  logic [N_SLV*DW-1:0] m_dat_i,
  output logic                err_irq_o,
  output logic [7:0]          err_count_o
);

  localparam int unsigned       IW      = idx_width(N_SLV);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);

  state_e              r_state, w_state_nxt;
  logic                r_we, w_we_nxt;
  logic [DW/8-1:0]     r_sel, w_sel_nxt;
  logic [SLV_AW-1:0]   r_adr, w_adr_nxt;
  logic [DW-1:0]       r_wdat, w_wdat_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [N_SLV-1:0]    r_mstb, w_mstb_nxt;
  logic                r_ack, w_ack_nxt;
  logic [DW-1:0]       r_dout, w_dout_nxt;
  logic                r_irq, w_irq_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;

  logic                w_hit;
  logic [IW-1:0]       w_dec_idx;
  logic [SLV_AW-1:0]   w_dec_off;
  logic                w_sel_ack;
  logic [DW-1:0]       w_sel_dat;
  logic                w_err;

  wb_addr_decoder #(
    .N_SLV     (N_SLV),
    .AW        (AW),
    .SLV_AW    (SLV_AW),
    .IW        (IW),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .i_adr (wbs_adr_i),
    .o_hit (w_hit),
    .o_idx (w_dec_idx),
    .o_off (w_dec_off)
  );

  // Only the selected target's ack/data are ever looked at; stray acks are ignored.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (r_idx == IW'(k)) begin
        w_sel_ack = m_ack_i[k];
        w_sel_dat = m_dat_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_adr_nxt   = r_adr;
    w_wdat_nxt  = r_wdat;
    w_idx_nxt   = r_idx;
    w_tmo_nxt   = r_tmo;
    w_mstb_nxt  = r_mstb;
    w_ack_nxt   = 1'b0;
    w_dout_nxt  = '0;
    w_err       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          w_we_nxt   = wbs_we_i;
          w_sel_nxt  = wbs_sel_i;
          w_adr_nxt  = w_dec_off;
          w_wdat_nxt = wbs_dat_i;
          if (w_hit) begin
            w_idx_nxt = w_dec_idx;
            w_tmo_nxt = '0;
            for (int k = 0; k < N_SLV; k++) begin
              w_mstb_nxt[k] = (w_dec_idx == IW'(k));
            end
            w_state_nxt = StAccess;
          end else begin
            w_state_nxt = StResp;
            w_ack_nxt   = 1'b1;
            w_err       = 1'b1;
            w_dout_nxt  = wbs_we_i ? '0 : ERR_DATA;
          end
        end
      end

      StAccess: begin
        if (!wbs_cyc_i) begin
          // Master gave up: release the target quietly, no response owed.
          w_mstb_nxt  = '0;
          w_state_nxt = StIdle;
        end else if (w_sel_ack) begin
          // Checked before the timeout so an ack on the last allowed cycle still counts.
          w_mstb_nxt  = '0;
          w_state_nxt = StResp;
          w_ack_nxt   = 1'b1;
          w_dout_nxt  = r_we ? '0 : w_sel_dat;
        end else if (r_tmo == TmoLast) begin
          w_mstb_nxt  = '0;
          w_state_nxt = StResp;
          w_ack_nxt   = 1'b1;
          w_err       = 1'b1;
          w_dout_nxt  = r_we ? '0 : ERR_DATA;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      StResp: begin
        // The response is already on the outputs; this hop back to idle gives the master
        // a cycle to drop stb so the same request is never taken twice.
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
        w_mstb_nxt  = '0;
      end
    endcase

    // Error pulse and count land in the same cycle as the upstream ack.
    w_irq_nxt = w_err;
    w_cnt_nxt = (w_err && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_mstb  <= '0;
      r_ack   <= 1'b0;
      r_dout  <= '0;
      r_irq   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_adr   <= w_adr_nxt;
      r_wdat  <= w_wdat_nxt;
      r_idx   <= w_idx_nxt;
      r_tmo   <= w_tmo_nxt;
      r_mstb  <= w_mstb_nxt;
      r_ack   <= w_ack_nxt;
      r_dout  <= w_dout_nxt;
      r_irq   <= w_irq_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dout;
  assign m_cyc_o     = r_mstb;
  assign m_stb_o     = r_mstb;
  assign m_we_o      = r_we;
  assign m_sel_o     = r_sel;
  assign m_adr_o     = r_adr;
  assign m_dat_o     = r_wdat;
  assign err_irq_o   = r_irq;
  assign err_count_o = r_cnt;

endmodule

// File: tb/tb_wb_mprj_bridge.sv
// Directed bench for wb_mprj_bridge (N_SLV=4, TIMEOUT=8). Each upstream transfer pushes its
// expected response to a scoreboard; a monitor pops and compares on every wbs_ack_o.
module tb_wb_mprj_bridge;

  localparam int unsigned TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [3:0]   mcyc, mstb;
  logic         mwe;
  logic [3:0]   msel;
  logic [19:0]  madr;
  logic [31:0]  mdat;
  logic [3:0]   mack;
  logic [127:0] mdin;
  logic         irq;
  logic [7:0]   cnt;

  typedef struct packed {
    logic [31:0] dat;
    logic        irq;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   mcnt  = 0;

  always #5 clk = ~clk;

  wb_mprj_bridge #(
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .m_cyc_o     (mcyc),
    .m_stb_o     (mstb),
    .m_we_o      (mwe),
    .m_sel_o     (msel),
    .m_adr_o     (madr),
    .m_dat_o     (mdat),
    .m_ack_i     (mack),
    .m_dat_i     (mdin),
    .err_irq_o   (irq),
    .err_count_o (cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      check("ack_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("resp_dat", 64'(rdat), 64'(mon_e.dat));
        check("resp_irq", 64'(irq), 64'(mon_e.irq));
        check("resp_cnt", 64'(cnt), 64'(mon_e.cnt));
      end
    end else begin
      check("idle_dat", 64'(rdat), 64'd0);
      check("idle_irq", 64'(irq), 64'd0);
    end
  end

  // One upstream transfer. idx<0: unmapped address; waits<0: target never acks.
  task automatic xfer(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_wdat,
                      input logic [3:0] t_sel, input int idx, input int waits,
                      input logic [31:0] t_rdat);
    logic       err;
    int         lat;
    int         c;
    logic [3:0] onehot;
    exp_t       e;
    bit         got;
    onehot = (idx >= 0) ? 4'(1 << idx) : 4'b0;
    err    = (idx < 0) || (waits < 0);
    lat    = (idx < 0) ? 1 : ((waits < 0) ? TMO + 1 : 2 + waits);
    if (err && mcnt < 255) mcnt++;
    e.dat = t_we ? 32'h0 : (err ? 32'hDEAD_BEEF : t_rdat);
    e.irq = err;
    e.cnt = 8'(mcnt);
    for (int k = 0; k < 4; k++) mdin[k*32 +: 32] = (k == idx) ? t_rdat : (32'hBAD0_0000 | k);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_wdat; sel = t_sel; mack = '0;
    sb.push_back(e);
    c   = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (c < lat) begin
        check("m_stb", 64'(mstb), 64'(onehot));
        check("m_cyc", 64'(mcyc), 64'(onehot));
      end else if (c == lat) begin
        check("m_stb_dropped", 64'(mstb), 64'd0);
      end
      if (c == 1 && idx >= 0) begin
        check("m_adr", 64'(madr), 64'(t_adr[19:0]));
        check("m_we", 64'(mwe), 64'(t_we));
        check("m_sel", 64'(msel), 64'(t_sel));
        check("m_dat", 64'(mdat), 64'(t_wdat));
      end
      if (ack === 1'b1) begin
        got = 1'b1;
        check("latency", 64'(c), 64'(lat));
        cyc = 1'b0; stb = 1'b0; mack = '0;
      end else if (waits >= 0 && c - 1 == waits) begin
        mack = onehot;
      end else begin
        mack = ~onehot;   // acks from unselected targets must be ignored
      end
    end
    check("ack_seen", 64'(got), 64'd1);
    cyc = 1'b0; stb = 1'b0; mack = '0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    mack = '0; mdin = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_mcyc", 64'(mcyc), 64'd0);
    check("rst_mstb", 64'(mstb), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_madr", 64'(madr), 64'd0);
    check("rst_mdat", 64'(mdat), 64'd0);
    rst = 1'b0;

    // Hits, misses, window edges, timeout and ack-on-timeout.
    xfer(1'b1, 32'h3010_0004, 32'hA5A5_A5A5, 4'hF, 1, 0, 32'h0);
    xfer(1'b0, 32'h3030_0000, 32'h0, 4'hF, 3, 3, 32'h1234_5678);
    xfer(1'b0, 32'h3040_0000, 32'h0, 4'hF, -1, 0, 32'h0);
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, -1, 32'h0);
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, TMO - 1, 32'hCAFE_F00D);
    xfer(1'b0, 32'h303F_FFFC, 32'h0, 4'hF, 3, 2, 32'h0BAD_C0DE);
    xfer(1'b0, 32'h2FFF_FFFC, 32'h0, 4'hF, -1, 0, 32'h0);
    xfer(1'b1, 32'hFFFF_FFFC, 32'h1111_2222, 4'hC, -1, 0, 32'h0);
    xfer(1'b1, 32'h3020_0100, 32'h5A5A_0000, 4'h1, 2, -1, 32'h0);

    // Abort: master drops cyc in the second ACCESS cycle.
    for (int k = 0; k < 4; k++) mdin[k*32 +: 32] = 32'h7777_0000 | k;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3020_0010; sel = 4'hF; mack = '0;
    @(negedge clk);
    check("abort_stb_c1", 64'(mstb), 64'h4);
    @(negedge clk);
    check("abort_stb_c2", 64'(mstb), 64'h4);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_mcyc", 64'(mcyc), 64'd0);
    check("abort_mstb", 64'(mstb), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_cnt", 64'(cnt), 64'(mcnt));

    // Reset in the middle of an ACCESS.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3010_0020; wdat = 32'h9999_8888; sel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_stb_before", 64'(mstb), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mcyc", 64'(mcyc), 64'd0);
    check("rst_mid_mstb", 64'(mstb), 64'd0);
    check("rst_mid_ack", 64'(ack), 64'd0);
    check("rst_mid_cnt", 64'(cnt), 64'd0);
    check("rst_mid_mwe", 64'(mwe), 64'd0);
    check("rst_mid_mdat", 64'(mdat), 64'd0);
    check("rst_mid_madr", 64'(madr), 64'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; mcnt = 0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      xfer(1'b0, 32'h3040_0000 + 32'(i * 4), 32'h0, 4'hF, -1, 0, 32'h0);
    end
    @(negedge clk);
    check("cnt_saturated", 64'(cnt), 64'hFF);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
